// File: rtl/tinyqv_slice_sequencer_pkg.sv
// Shared definitions for the slice sequencer:
// beat-count derivation and FSM state encoding.
package tinyqv_slice_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int nbeats_of(input int word_w, input int slice_w);
        return word_w / slice_w;
    endfunction

    function automatic int cnt_w_of(input int nbeats);
        return $clog2(nbeats);
    endfunction

endpackage

// File: rtl/tinyqv_slice_sequencer_if.sv
// Word/slice bus between parallel sources/sinks and the sequencer.
// master drives words and handshakes, slave is the sequencer.
interface tinyqv_slice_sequencer_if #(
    parameter int WORD_W  = 32,
    parameter int SLICE_W = 4,
    parameter int LANES   = 2
);
    import tinyqv_slice_pkg::*;

    localparam int CNT_W = cnt_w_of(nbeats_of(WORD_W, SLICE_W));

    logic                       start;
    logic                       stall;
    logic [LANES*WORD_W-1:0]    tx_word;
    logic [LANES*SLICE_W-1:0]   tx_slice;
    logic [LANES*SLICE_W-1:0]   rx_slice;
    logic [LANES*WORD_W-1:0]    rx_word;
    logic [LANES*WORD_W-1:0]    rx_word_bypass;
    logic [CNT_W-1:0]           cnt;
    logic                       busy;
    logic                       last;
    logic                       done;

    modport master (
        output start, stall, tx_word, rx_slice,
        input  tx_slice, rx_word, rx_word_bypass,
        input  cnt, busy, last, done
    );

    modport slave (
        input  start, stall, tx_word, rx_slice,
        output tx_slice, rx_word, rx_word_bypass,
        output cnt, busy, last, done
    );

endinterface

// File: rtl/tinyqv_slice_sequencer_lane.sv
// One lane: tx word register with slice mux and
// rx reassembly register with slice demux.
module tinyqv_slice_lane #(
    parameter int WORD_W   = 32,
    parameter int SLICE_W  = 4,
    parameter int CNT_W    = 3,
    parameter int FREE_RUN = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               capture,
    input  logic               consume,
    input  logic               busy,
    input  logic [CNT_W-1:0]   cnt,
    input  logic [WORD_W-1:0]  tx_word,
    input  logic [SLICE_W-1:0] rx_slice,
    output logic [SLICE_W-1:0] tx_slice,
    output logic [WORD_W-1:0]  rx_word,
    output logic [WORD_W-1:0]  rx_word_bypass
);
    localparam int NBEATS = WORD_W / SLICE_W;

    logic [WORD_W-1:0]  tx_reg;
    logic [WORD_W-1:0]  rx_reg;
    logic [WORD_W-1:0]  tx_src;
    logic [SLICE_W-1:0] tx_sel;

    // latch the outgoing word when a transfer starts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tx_reg <= '0;
        else if (capture)
            tx_reg <= tx_word;
    end

    // drop each consumed rx slice into its beat position
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_reg <= '0;
        end else if (consume) begin
            for (int b = 0; b < NBEATS; b++)
                if (cnt == CNT_W'(b))
                    rx_reg[b*SLICE_W +: SLICE_W] <= rx_slice;
        end
    end

    // free-run lanes serialise the live word, others the captured one
    always_comb begin
        tx_src = (FREE_RUN != 0) ? tx_word : tx_reg;
        tx_sel = '0;
        for (int b = 0; b < NBEATS; b++)
            if (cnt == CNT_W'(b))
                tx_sel = tx_src[b*SLICE_W +: SLICE_W];
        tx_slice = busy ? tx_sel : '0;
    end

    assign rx_word        = rx_reg;
    assign rx_word_bypass = {rx_slice, rx_reg[WORD_W-SLICE_W-1:0]};

endmodule

// File: rtl/tinyqv_slice_sequencer.sv
// Beat counter and transfer FSM shared by all lanes;
// per-lane slice (de)serialisation lives in tinyqv_slice_lane.
module tinyqv_slice_sequencer #(
    parameter int WORD_W   = 32,
    parameter int SLICE_W  = 4,
    parameter int LANES    = 2,
    parameter int FREE_RUN = 0
) (
    input logic                    clk,
    input logic                    rstn,
    tinyqv_slice_sequencer_if.slave bus
);
    import tinyqv_slice_pkg::*;

    localparam int NBEATS = nbeats_of(WORD_W, SLICE_W);
    localparam int CNT_W  = cnt_w_of(NBEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);
    localparam state_e ST_RESET = (FREE_RUN != 0) ? ST_RUN : ST_IDLE;

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             done, done_n;
    logic             busy, last, consume, capture;

    logic [SLICE_W-1:0] lane_tx  [LANES];
    logic [WORD_W-1:0]  lane_rx  [LANES];
    logic [WORD_W-1:0]  lane_byp [LANES];

    // state, beat counter and done pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_RESET;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            done  <= done_n;
        end
    end

    // next state: start in IDLE, advance on consumed beats, chain on last
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        capture = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && FREE_RUN == 0) begin
                    capture = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        done_n = 1'b1;
                        if (FREE_RUN == 0) begin
                            if (bus.start)
                                capture = 1'b1;
                            else
                                state_n = ST_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    // status outputs derived from the registers
    always_comb begin
        busy     = (state == ST_RUN);
        last     = busy && (cnt == CNT_LAST);
        consume  = busy && !bus.stall;
        bus.busy = busy;
        bus.last = last;
        bus.cnt  = cnt;
        bus.done = done;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tinyqv_slice_lane #(
            .WORD_W   (WORD_W),
            .SLICE_W  (SLICE_W),
            .CNT_W    (CNT_W),
            .FREE_RUN (FREE_RUN)
        ) u_lane (
            .clk            (clk),
            .rstn           (rstn),
            .capture        (capture),
            .consume        (consume),
            .busy           (busy),
            .cnt            (cnt),
            .tx_word        (bus.tx_word[i*WORD_W +: WORD_W]),
            .rx_slice       (bus.rx_slice[i*SLICE_W +: SLICE_W]),
            .tx_slice       (lane_tx[i]),
            .rx_word        (lane_rx[i]),
            .rx_word_bypass (lane_byp[i])
        );
    end

    // pack per-lane results onto the flat bus
    always_comb begin
        bus.tx_slice       = '0;
        bus.rx_word        = '0;
        bus.rx_word_bypass = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.tx_slice[i*SLICE_W +: SLICE_W]     = lane_tx[i];
            bus.rx_word[i*WORD_W +: WORD_W]        = lane_rx[i];
            bus.rx_word_bypass[i*WORD_W +: WORD_W] = lane_byp[i];
        end
    end

endmodule

// File: doc/tinyqv_slice_sequencer.md
Name: tinyqv_slice_sequencer

Overview:
Parametrised slice sequencer for the nibble-serial datapath. It generalises the fixed 32-bit, 4-bit-per-cycle counter/reassembly harness around the core to any word and slice width, multiple lanes and two modes. The block serialises parallel words into per-cycle slices, deserialises returning slices into words, and exports the beat counter. It has start/stall/done handshakes and supports back-to-back transfers. It sits between parallel word sources or sinks (testbench, peripherals, debug) and the slice-serial core interface.

Parameters:
WORD_W, 32, bits per word; must be a multiple of SLICE_W
SLICE_W, 4, bits moved per beat
LANES, 2, independent tx/rx channel pairs that share one counter
FREE_RUN, 0, 0 = start-triggered transfers; 1 = continuously wrapping counter with no tx capture
Derived: NBEATS = WORD_W/SLICE_W, a power of two and at least 2; CNT_W = clog2(NBEATS)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  request a transfer; ignored when FREE_RUN=1
stall  in  1  hold the counter and all registers for this cycle
tx_word  in  LANES*WORD_W  parallel words; lane i at [i*WORD_W +: WORD_W]
tx_slice  out  LANES*SLICE_W  current tx slice per lane
rx_slice  in  LANES*SLICE_W  incoming slice per lane
rx_word  out  LANES*WORD_W  registered reassembled words
rx_word_bypass  out  LANES*WORD_W  {rx_slice, rx_reg[WORD_W-SLICE_W-1:0]} per lane; complete during the last beat
cnt  out  CNT_W  current beat index
busy  out  1  high in RUN
last  out  1  busy & cnt==NBEATS-1
done  out  1  one-cycle registered pulse after the last beat is consumed

Behaviour:
- Reset (asynchronous): state=IDLE (RUN if FREE_RUN=1), cnt=0, done=0, tx_reg=0, rx_reg=0. All outputs are derived from these registers.
- A beat is consumed on any cycle with busy & !stall.
- States, FREE_RUN=0:
  - IDLE: busy=0, tx_slice=0. If start=1, capture tx_word into tx_reg, set cnt=0 and go to RUN. Beat 0 is presented on the next cycle.
  - RUN, consumed beat with cnt<NBEATS-1: cnt <= cnt+1.
  - RUN, consumed beat with cnt==NBEATS-1: done <= 1 next cycle.
    - If start=1: recapture tx_word, set cnt=0 and stay in RUN (back-to-back, no bubble).
    - Otherwise go to IDLE with cnt=0.
  - start in RUN when not on the last consumed beat: ignored, no error.
- FREE_RUN=1: always in RUN. cnt increments modulo NBEATS on each non-stalled cycle. tx_slice = tx_word[cnt*SLICE_W +: SLICE_W], combinational with no capture. done pulses on the cycle after each wrap.
- tx_slice (FREE_RUN=0): tx_reg[cnt*SLICE_W +: SLICE_W] per lane.
- rx: on a consumed beat, rx_reg[cnt*SLICE_W +: SLICE_W] <= rx_slice per lane. rx_word = rx_reg, complete and stable from the done cycle until the next consumed beat 0.
- stall:
  - Freezes cnt, tx_reg, rx_reg and state.
  - A stall on the last beat delays done.
  - start is sampled only on non-stalled last beats or in IDLE; stall has no effect in IDLE.
- done never coincides with reset. Reset asserted mid-transfer aborts the transfer: no done, and rx_reg is cleared.
- Widths: cnt wraps naturally at NBEATS; slice indexing needs no bounds checks beyond the parameter constraints.

Decomposition:
- Shared package tinyqv_slice_pkg: NBEATS/CNT_W derivation function and state encoding constants ST_IDLE, ST_RUN.
- One sub-module, tinyqv_slice_lane: holds tx_reg/rx_reg and the slice mux/demux for one lane. It is instantiated LANES times by generate.
- The counter and FSM live in the top module.

Test Plan:
- Default parameters. start with lane0=0x89ABCDEF, lane1=0x12345678 → over 8 beats tx_slice lane0 = F,E,D,C,B,A,9,8 and lane1 = 8,7,…,1; done at cycle 9; busy low after.
- rx loopback (rx_slice=tx_slice), word 0xDEADBEEF → rx_word=0xDEADBEEF on done. During beat 7, rx_word_bypass=0xDEADBEEF.
- start held through the last beat with a new word 0x0F0F0F0F → cnt goes 7→0 with no idle cycle, done pulses once per word, and tx_slice shows F,0,F,0….
- stall asserted at beats 3 and 7 for 2 cycles each → cnt holds, slices repeat, done delayed by 4 cycles, and rx_word is still correct.
- rstn dropped at beat 5 → outputs zero immediately (asynchronously), no done pulse, IDLE after release.
- FREE_RUN=1, WORD_W=16, SLICE_W=2, LANES=1 → cnt cycles 0..7 continuously, done every 8 cycles, tx_slice follows a live tx_word change within the same cycle.
